// File: rtl/cpu_dump_ctrl.sv
// Run-control and end-of-program state dump for the CPU: runs it for a cycle budget or until a
// chosen PC retires, then freezes it and streams the register file and a data-memory window out.
module cpu_dump_ctrl #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned RF_AW     = 5,
  parameter int unsigned MEM_WORDS = 9,
  parameter int unsigned MEM_BASE  = 0,
  parameter int unsigned DM_AW     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      cycle_limit,
  input  logic [31:0]      halt_pc,
  input  logic             halt_pc_en,
  input  logic             wb_valid,
  input  logic [31:0]      wb_pc,
  output logic             cpu_run,
  output logic [RF_AW-1:0] rf_raddr,
  input  logic [31:0]      rf_rdata,
  output logic [DM_AW-1:0] dm_raddr,
  input  logic [31:0]      dm_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_is_mem,
  output logic [15:0]      out_index,
  output logic [31:0]      cycles,
  output logic [1:0]       stop_reason,
  output logic             done
);

  typedef enum logic [2:0] {StIdle, StRun, StDumpRf, StDumpMem, StDone} state_e;

  state_e           state_q;
  logic [31:0]      limit_q, halt_pc_q, cycles_q;
  logic             halt_en_q;
  logic             cpu_run_q, out_valid_q, out_is_mem_q, done_q;
  logic [15:0]      out_index_q;
  logic [1:0]       stop_reason_q;
  logic [RF_AW-1:0] rf_raddr_q;
  logic [DM_AW-1:0] dm_raddr_q;

  logic [31:0] cycles_inc;
  logic        stop_budget, stop_halt, beat_done, last_rf, last_mem;

  // A saturated counter wraps cycles_inc to 0, which can never equal a nonzero limit.
  assign cycles_inc  = cycles_q + 32'd1;
  assign stop_budget = (limit_q != 32'd0) && (cycles_inc == limit_q);
  assign stop_halt   = halt_en_q && wb_valid && (wb_pc == halt_pc_q);
  assign beat_done   = out_valid_q && out_ready;
  assign last_rf     = out_index_q == 16'(NUM_REGS - 1);
  assign last_mem    = out_index_q == 16'(MEM_WORDS - 1);

  always_comb begin
    out_data = 32'd0;
    if (out_valid_q) begin
      if (out_is_mem_q)              out_data = dm_rdata;
      else if (out_index_q != 16'd0) out_data = rf_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      limit_q       <= 32'd0;
      halt_pc_q     <= 32'd0;
      halt_en_q     <= 1'b0;
      cycles_q      <= 32'd0;
      cpu_run_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_is_mem_q  <= 1'b0;
      out_index_q   <= 16'd0;
      stop_reason_q <= 2'b00;
      done_q        <= 1'b0;
      rf_raddr_q    <= '0;
      dm_raddr_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            limit_q       <= cycle_limit;
            halt_pc_q     <= halt_pc;
            halt_en_q     <= halt_pc_en;
            cycles_q      <= 32'd0;
            stop_reason_q <= 2'b00;
            done_q        <= 1'b0;
            cpu_run_q     <= 1'b1;
            state_q       <= StRun;
          end
        end
        StRun: begin
          if (cycles_q != 32'hFFFF_FFFF) cycles_q <= cycles_inc;
          if (stop_budget || stop_halt) begin
            stop_reason_q <= {stop_halt, stop_budget};
            cpu_run_q     <= 1'b0;
            out_valid_q   <= 1'b1;
            out_is_mem_q  <= 1'b0;
            out_index_q   <= 16'd0;
            rf_raddr_q    <= '0;
            state_q       <= StDumpRf;
          end
        end
        StDumpRf: begin
          if (beat_done) begin
            if (!last_rf) begin
              out_index_q <= out_index_q + 16'd1;
              rf_raddr_q  <= rf_raddr_q + 1'b1;
            end else if (MEM_WORDS == 0) begin
              out_valid_q <= 1'b0;
              out_index_q <= 16'd0;
              done_q      <= 1'b1;
              state_q     <= StDone;
            end else begin
              out_is_mem_q <= 1'b1;
              out_index_q  <= 16'd0;
              dm_raddr_q   <= DM_AW'(MEM_BASE);
              state_q      <= StDumpMem;
            end
          end
        end
        StDumpMem: begin
          if (beat_done) begin
            if (!last_mem) begin
              out_index_q <= out_index_q + 16'd1;
              dm_raddr_q  <= dm_raddr_q + 1'b1;
            end else begin
              out_valid_q  <= 1'b0;
              out_is_mem_q <= 1'b0;
              out_index_q  <= 16'd0;
              done_q       <= 1'b1;
              state_q      <= StDone;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu_run     = cpu_run_q;
  assign rf_raddr    = rf_raddr_q;
  assign dm_raddr    = dm_raddr_q;
  assign out_valid   = out_valid_q;
  assign out_is_mem  = out_is_mem_q;
  assign out_index   = out_index_q;
  assign cycles      = cycles_q;
  assign stop_reason = stop_reason_q;
  assign done        = done_q;

endmodule

// File: tb/tb_cpu_dump_ctrl.sv
// Randomized bench for cpu_dump_ctrl: expected dump beats are queued when a run is launched and
// a negedge monitor pops and compares every transferred beat.
module tb_cpu_dump_ctrl;

  localparam int NR = 32;
  localparam int MW = 9;
  localparam int MB = 0;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] cycle_limit = '0, halt_pc = '0, wb_pc = '0;
  logic        halt_pc_en = 1'b0, wb_valid = 1'b0, out_ready = 1'b0;
  logic        cpu_run, out_valid, out_is_mem, done;
  logic [4:0]  rf_raddr;
  logic [9:0]  dm_raddr;
  logic [31:0] rf_rdata, dm_rdata, out_data, cycles;
  logic [15:0] out_index;
  logic [1:0]  stop_reason;

  logic [31:0] rf [NR];
  logic [31:0] dm [1024];
  assign rf_rdata = rf[rf_raddr];
  assign dm_rdata = dm[dm_raddr];

  always #5 clk = ~clk;

  cpu_dump_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cycle_limit(cycle_limit), .halt_pc(halt_pc),
    .halt_pc_en(halt_pc_en), .wb_valid(wb_valid), .wb_pc(wb_pc), .cpu_run(cpu_run),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_is_mem(out_is_mem),
    .out_index(out_index), .cycles(cycles), .stop_reason(stop_reason), .done(done)
  );

  typedef struct packed {
    logic        is_mem;
    logic [15:0] idx;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_cur, mon_exp, held;
  logic  held_v = 1'b0;
  int    n_vec = 0, n_err = 0, beats = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every transferred beat is compared with the scoreboard head.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      held_v = 1'b0;
    end else if (out_valid === 1'b1) begin
      mon_cur = {out_is_mem, out_index, out_data};
      if (held_v) check("stall_stable", 64'(mon_cur), 64'(held));
      if (out_ready) begin
        held_v = 1'b0;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_beat: got %h want none", mon_cur);
        end else begin
          mon_exp = exp_q.pop_front();
          check($sformatf("beat%0d", beats), 64'(mon_cur), 64'(mon_exp));
        end
        beats++;
      end else begin
        held   = mon_cur;
        held_v = 1'b1;
      end
    end else if (held_v) begin
      check("valid_dropped", 64'(out_valid), 64'd1);
      held_v = 1'b0;
    end
  end

  task automatic load_and_expect();
    beat_t b;
    for (int i = 0; i < NR; i++) rf[i] = $urandom;
    for (int i = 0; i < 1024; i++) dm[i] = $urandom;
    rf[0] = 32'hFFFF_FFFF;
    rf[1] = 32'h1234_5678;
    dm[(MB + 8) % 1024] = 32'hDEAD_BEEF;
    for (int i = 0; i < NR; i++) begin
      b = {1'b0, 16'(i), (i == 0) ? 32'd0 : rf[i]};
      exp_q.push_back(b);
    end
    for (int i = 0; i < MW; i++) begin
      b = {1'b1, 16'(i), dm[(MB + i) % 1024]};
      exp_q.push_back(b);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_a"}, {cpu_run, out_valid, out_data, out_is_mem, out_index}, 64'd0);
    check({name, "_b"}, {cycles, stop_reason, done, rf_raddr, dm_raddr}, 64'd0);
  endtask

  // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run_test(input logic [31:0] limit, input bit hen, input int hcyc, input int mode);
    logic [31:0] hp;
    int          exp_run, k, c;
    logic [1:0]  exp_reason;
    logic [3:0]  pat;
    pat = 4'b1001;
    hp  = hen ? 32'h0000_3010 : $urandom;
    // Reference: the run stops at the earlier of the budget and the halt retirement.
    exp_run = 1000;
    if (limit != 0) exp_run = int'(limit);
    if (hen && hcyc < exp_run) exp_run = hcyc;
    exp_reason = {hen && (hcyc == exp_run), (limit != 0) && (int'(limit) == exp_run)};
    load_and_expect();
    @(posedge clk); #1;
    cycle_limit = limit; halt_pc = hp; halt_pc_en = hen; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cycle_limit = $urandom; halt_pc = ~hp; halt_pc_en = ~hen;
    k = 1;
    while (cpu_run === 1'b1 && k <= 200) begin
      check("run_cycles", 64'(cycles), 64'(k - 1));
      start = (k == 2);
      if (hen) begin
        wb_valid = (k == hcyc) || ($urandom % 2 == 1);
        wb_pc    = (k == hcyc) ? hp : hp ^ (32'h4 << ($urandom % 8));
      end else begin
        wb_valid = $urandom % 2 == 1;
        wb_pc    = hp;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0; wb_valid = 1'b0;
    check("run_length", 64'(k - 1), 64'(exp_run));
    check("cycles_stop", 64'(cycles), 64'(exp_run));
    check("stop_reason", 64'(stop_reason), 64'(exp_reason));
    check("first_valid", 64'(out_valid), 64'd1);
    c = 0;
    while (done !== 1'b1 && c < 400) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[c % 4] : 1'($urandom % 2);
      @(posedge clk); #1;
      c++;
    end
    out_ready = 1'b0;
    if (mode == 0) check("done_latency", 64'(c), 64'(NR + MW));
    check("done", 64'(done), 64'd1);
    check("beats_left", 64'(exp_q.size()), 64'd0);
    check("done_idle", {cpu_run, out_valid}, 64'd0);
    check("cycles_hold", 64'(cycles), 64'(exp_run));
    repeat (2) @(posedge clk);
    #1;
    check("done_stays", {done, stop_reason}, {1'b1, exp_reason});
  endtask

  task automatic reset_test();
    int b0, c;
    load_and_expect();
    @(posedge clk); #1;
    cycle_limit = 32'd3; halt_pc_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b1;
    c = 0;
    while (out_valid !== 1'b1 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    b0 = beats;
    c = 0;
    while (beats < b0 + 10 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check("reset_reach_beat10", 64'(beats - b0 >= 10), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("mid_dump_reset");
    rst = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("no_partial_done", {done, out_valid, cpu_run}, 64'd0);
  endtask

  initial begin
    logic [31:0] lim;
    bit          hen;
    int          hc;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    run_test(32'd5, 1'b0, 0, 0);
    run_test(32'd0, 1'b1, 7, 1);
    run_test(32'd7, 1'b1, 7, 0);
    reset_test();
    run_test(32'd4, 1'b0, 0, 0);
    for (int t = 0; t < 5; t++) begin
      hen = $urandom % 2 == 1;
      hc  = 1 + $urandom % 20;
      lim = hen && ($urandom % 3 == 0) ? 32'd0 : 32'(1 + $urandom % 20);
      run_test(lim, hen, hc, 2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
